// File: rtl/rv_dbus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_dbus_pkg : shared MMIO map and UART FSM encodings for rv_dbus     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv_dbus_pkg;

   localparam int MMIO_SEL_BIT = 12;

   localparam logic [2:0] MMIO_LED       = 3'd0;
   localparam logic [2:0] MMIO_TIMER     = 3'd1;
   localparam logic [2:0] MMIO_UART_DATA = 3'd2;
   localparam logic [2:0] MMIO_UART_STAT = 3'd3;

   localparam logic [1:0] UART_IDLE  = 2'd0;
   localparam logic [1:0] UART_START = 2'd1;
   localparam logic [1:0] UART_DATA  = 2'd2;
   localparam logic [1:0] UART_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rv_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_uart_tx : 8N1 serial transmitter, one byte per load while idle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rv_uart_tx
   import rv_dbus_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx
);

   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] C_BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   logic [1:0]    r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          w_baud_end;

   assign w_baud_end = (r_baud == C_BAUD_LAST);
   assign busy       = (r_state != UART_IDLE);
   assign tx         = r_tx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= UART_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         // Line is driven from the state one cycle late, so tx falls the edge after load.
         case (r_state)
            UART_START: r_tx <= 1'b0;
            UART_DATA:  r_tx <= r_shift[0];
            default:    r_tx <= 1'b1;
         endcase

         if (r_state == UART_IDLE) begin
            r_baud <= '0;
            if (load) begin
               r_shift <= data;
               r_state <= UART_START;
            end
         end else if (!w_baud_end) begin
            r_baud <= r_baud + BW'(1);
         end else begin
            r_baud <= '0;
            case (r_state)
               UART_START: begin
                  r_bit   <= '0;
                  r_state <= UART_DATA;
               end
               UART_DATA: begin
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bit == 3'd7) begin
                     r_state <= UART_STOP;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                  end
               end
               default: r_state <= UART_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rv_dbus.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_dbus : core data-bus decode to data RAM, LEDs, timer and UART TX  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rv_dbus
   import rv_dbus_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int MEM_WORDS    = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dout,
   input  logic        drw,
   output logic [31:0] din,
   output logic [2:0]  leds,
   output logic        uart_tx
);

   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0]   r_mem [MEM_WORDS];
   logic [31:0]   r_ram_rd;
   logic [31:0]   r_mmio_rd;
   logic          r_rd_ram;
   logic          r_drw_q;
   logic [2:0]    r_leds;
   logic [31:0]   r_timer;

   logic          w_wstb;
   logic          w_is_mmio;
   logic [2:0]    w_off;
   logic [AW-1:0] w_widx;
   logic [31:0]   w_mmio_rd;
   logic          w_uart_load;
   logic          w_busy;
   logic          w_unused;

   assign w_wstb      = drw & ~r_drw_q;
   assign w_is_mmio   = daddr[MMIO_SEL_BIT];
   assign w_off       = daddr[4:2];
   assign w_widx      = daddr[AW+1:2];
   assign w_uart_load = w_wstb & w_is_mmio & (w_off == MMIO_UART_DATA);
   assign w_unused    = ^{daddr[31:13], daddr[1:0]};

   assign din  = r_rd_ram ? r_ram_rd : r_mmio_rd;
   assign leds = r_leds;

   // No reset on the array so it maps onto block RAM; read-before-write on collision.
   always_ff @(posedge clk) begin
      if (w_wstb && !w_is_mmio) begin
         r_mem[w_widx] <= dout;
      end
      r_ram_rd <= r_mem[w_widx];
   end

   always_comb begin
      w_mmio_rd = '0;
      case (w_off)
         MMIO_LED:       w_mmio_rd = {29'd0, r_leds};
         MMIO_TIMER:     w_mmio_rd = r_timer;
         MMIO_UART_STAT: w_mmio_rd = {31'd0, w_busy};
         default:        w_mmio_rd = '0;
      endcase
   end

   // r_rd_ram clears on reset so din reads zero without resetting the RAM output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_drw_q   <= 1'b0;
         r_leds    <= '0;
         r_timer   <= '0;
         r_mmio_rd <= '0;
         r_rd_ram  <= 1'b0;
      end else begin
         r_drw_q   <= drw;
         r_timer   <= r_timer + 32'd1;
         r_mmio_rd <= w_mmio_rd;
         r_rd_ram  <= ~w_is_mmio;
         if (w_wstb && w_is_mmio && (w_off == MMIO_LED)) begin
            r_leds <= dout[2:0];
         end
      end
   end

   rv_uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk   (clk),
      .reset (reset),
      .load  (w_uart_load),
      .data  (dout[7:0]),
      .busy  (w_busy),
      .tx    (uart_tx)
   );

endmodule
`default_nettype wire

// File: tb/tb_rv_dbus.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv_dbus : directed + random bench for rv_dbus with bus-level model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rv_dbus;
   import rv_dbus_pkg::*;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] daddr = '0;
   logic [31:0] dout  = '0;
   logic        drw   = 1'b0;
   logic [31:0] din;
   logic [2:0]  leds;
   logic        uart_tx;

   rv_dbus #(
      .CLKS_PER_BIT (CPB),
      .MEM_WORDS    (1024)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .daddr   (daddr),
      .dout    (dout),
      .drw     (drw),
      .din     (din),
      .leds    (leds),
      .uart_tx (uart_tx)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: bus-level view of memory, LEDs, elapsed cycles and the frame in flight.
   logic [31:0] m_ram [1024];
   int          n        = 0;
   int          m_fstart = -1;
   logic [7:0]  m_byte   = '0;
   logic [2:0]  m_leds   = '0;
   logic        m_prev_rw = 1'b0;
   logic        txlog [4096];

   function automatic logic busy_after(input int e);
      return (m_fstart >= 0) && (e >= m_fstart) && (e < m_fstart + FRAME);
   endfunction

   // Line level after edge e: start bit, 8 data bits LSB first, stop bit.
   function automatic logic exp_tx(input int e);
      int k;
      int b;
      k = e - m_fstart - 1;
      if (m_fstart < 0 || k < 0 || k >= FRAME) return 1'b1;
      b = k / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_byte[b-1];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [31:0] a, input logic [31:0] d, input logic rw);
      logic [31:0] exp_din;
      logic        wstb;
      int          e;
      daddr = a;
      dout  = d;
      drw   = rw;
      exp_din = '0;
      if (!a[12]) begin
         exp_din = m_ram[a[11:2]];
      end else begin
         case (a[4:2])
            MMIO_LED:       exp_din = {29'd0, m_leds};
            MMIO_TIMER:     exp_din = 32'(n);
            MMIO_UART_STAT: exp_din = {31'd0, busy_after(n)};
            default:        exp_din = '0;
         endcase
      end
      wstb      = rw && !m_prev_rw;
      m_prev_rw = rw;
      e         = n + 1;
      if (wstb) begin
         if (!a[12]) m_ram[a[11:2]] = d;
         else if (a[4:2] == MMIO_LED) m_leds = d[2:0];
         else if (a[4:2] == MMIO_UART_DATA && !busy_after(n)) begin
            m_fstart = e;
            m_byte   = d[7:0];
         end
      end
      @(posedge clk);
      n = e;
      @(negedge clk);
      chk("din", din, exp_din);
      chk("leds", {29'd0, leds}, {29'd0, m_leds});
      chk("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx(n)});
      txlog[n % 4096] = uart_tx;
   endtask

   task automatic do_reset();
      drw = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("rst_din", din, 32'd0);
      chk("rst_leds", {29'd0, leds}, 32'd0);
      chk("rst_tx", {31'd0, uart_tx}, 32'd1);
      n = 0;
      m_fstart  = -1;
      m_leds    = '0;
      m_prev_rw = 1'b0;
      @(negedge clk);
      chk("rst_hold_din", din, 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int          ws;
      logic [31:0] r;
      logic [31:0] a;
      logic [9:0]  pat55;

      do_reset();

      for (int i = 0; i < 32; i++) begin
         step(32'(i * 4), 32'd0, 1'b1);
         step(32'(i * 4), 32'd0, 1'b0);
      end

      // RAM write with drw held, then read back one cycle later
      step(32'h0040, 32'hCAFEBABE, 1'b1);
      step(32'h0040, 32'hCAFEBABE, 1'b1);
      step(32'h0040, 32'hCAFEBABE, 1'b1);
      step(32'h0040, 32'd0, 1'b0);
      chk("ram_rd_40", din, 32'hCAFEBABE);
      step(32'h0044, 32'd0, 1'b0);
      chk("ram_rd_44", din, 32'd0);
      step(32'h0048, 32'h12345678, 1'b1);
      chk("ram_rbw_old", din, 32'd0);
      step(32'h0048, 32'd0, 1'b0);
      chk("ram_rbw_new", din, 32'h12345678);

      // LED register and reserved offset
      step(32'h1000, 32'h5, 1'b1);
      chk("led_wr", {29'd0, leds}, 32'h5);
      step(32'h1000, 32'd0, 1'b0);
      chk("led_rd", din, 32'h5);
      step(32'h101C, 32'h7, 1'b1);
      step(32'h101C, 32'd0, 1'b0);
      chk("rsvd_leds", {29'd0, leds}, 32'h5);
      chk("rsvd_rd", din, 32'd0);

      // One frame from a 5-cycle held store of 0x55
      for (int i = 0; i < 5; i++) step(32'h1008, 32'h55, 1'b1);
      ws = m_fstart;
      for (int i = 0; i < FRAME + 4; i++) step(32'h100C, 32'd0, 1'b0);
      pat55 = 10'b1010101010;
      for (int b = 0; b < 10; b++) begin
         chk("frame55_bit", {31'd0, txlog[(ws + 1 + b * CPB + CPB / 2) % 4096]}, {31'd0, pat55[b]});
      end
      chk("frame55_idle", din, 32'd0);

      // Second write while busy is dropped
      step(32'h1008, 32'hA5, 1'b1);
      for (int i = 0; i < 7; i++) step(32'h100C, 32'd0, 1'b0);
      step(32'h1008, 32'h3C, 1'b1);
      for (int i = 0; i < FRAME + 4; i++) step(32'h100C, 32'd0, 1'b0);
      chk("busy_clear", din, 32'd0);

      // Randomized mixed traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom();
         a = r;
         if ($urandom_range(0, 1) == 0) begin
            a[12]   = 1'b0;
            a[11:2] = 10'($urandom_range(0, 31));
         end else begin
            a[12]  = 1'b1;
            a[4:2] = 3'($urandom_range(0, 7));
         end
         step(a, $urandom(), ($urandom_range(0, 9) < 4));
      end
      step(32'h1000, 32'd0, 1'b0);
      for (int i = 0; i < FRAME + 2; i++) step(32'h1004, 32'd0, 1'b0);

      // Reset during data bit 3
      step(32'h1000, 32'h6, 1'b1);
      step(32'h1000, 32'd0, 1'b0);
      step(32'h1008, 32'h96, 1'b1);
      for (int i = 0; i < 4 * CPB + 2; i++) step(32'h1000, 32'd0, 1'b0);
      chk("pre_rst_din", din, 32'h6);
      do_reset();
      step(32'h100C, 32'd0, 1'b0);
      chk("post_rst_busy", din, 32'd0);
      step(32'h1008, 32'hC3, 1'b1);
      for (int i = 0; i < FRAME + 4; i++) step(32'h100C, 32'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
